// File: rtl/mem_requester_if.sv
// Request/response bus between the control unit, mem_requester and the memory responder.
// The master modport is the requester's view; slave is the environment's view.
interface mem_requester_if;
  logic        REQ;
  logic        REQ_RW;
  logic [15:0] REQ_ADDR;
  logic [15:0] REQ_WDATA;
  logic        R;
  logic [15:0] MEM_RDATA;
  logic [15:0] MAR_OUT;
  logic [15:0] MDR_OUT;
  logic        RW;
  logic        MEM_EN;
  logic        MIO_EN;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [15:0] RDATA;

  modport master (
    input  REQ, REQ_RW, REQ_ADDR, REQ_WDATA, R, MEM_RDATA,
    output MAR_OUT, MDR_OUT, RW, MEM_EN, MIO_EN, BUSY, DONE, ERR, RDATA
  );

  modport slave (
    output REQ, REQ_RW, REQ_ADDR, REQ_WDATA, R, MEM_RDATA,
    input  MAR_OUT, MDR_OUT, RW, MEM_EN, MIO_EN, BUSY, DONE, ERR, RDATA
  );
endinterface

// File: rtl/mem_requester.sv
// Four-phase memory access requester with ready timeout and IO-region flag.
//   state   | meaning
//   IDLE    | waiting for REQ with R low; outputs parked
//   ACCESS  | MEM_EN high, waiting for R or timeout
//   RECOVER | access finished, waiting for R to drop
module mem_requester #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter logic [15:0] IO_BASE        = 16'hFE00
) (
  input  logic          i_Clk,
  input  logic          i_Rst_n,
  mem_requester_if.master bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

  localparam logic [7:0] TIMEOUT = 8'(TIMEOUT_CYCLES);

  state_t     state;
  logic [7:0] cnt;
  logic [7:0] cnt_inc;

  // counter saturates instead of wrapping
  assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      bus.MAR_OUT <= 16'd0;
      bus.MDR_OUT <= 16'd0;
      bus.RW      <= 1'b0;
      bus.MEM_EN  <= 1'b0;
      bus.MIO_EN  <= 1'b0;
      bus.BUSY    <= 1'b0;
      bus.DONE    <= 1'b0;
      bus.ERR     <= 1'b0;
      bus.RDATA   <= 16'd0;
    end else begin
      bus.DONE <= 1'b0;
      case (state)
        IDLE: begin
          // a still-high R belongs to the previous access, so wait for it to drop
          if (bus.REQ && !bus.R) begin
            bus.MAR_OUT <= bus.REQ_ADDR;
            bus.MDR_OUT <= bus.REQ_WDATA;
            bus.RW      <= bus.REQ_RW;
            bus.MEM_EN  <= 1'b1;
            bus.MIO_EN  <= (bus.REQ_ADDR >= IO_BASE);
            bus.BUSY    <= 1'b1;
            cnt         <= 8'd0;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          if (bus.R) begin
            if (!bus.RW) bus.RDATA <= bus.MEM_RDATA;
            bus.MEM_EN <= 1'b0;
            bus.MIO_EN <= 1'b0;
            bus.DONE   <= 1'b1;
            bus.ERR    <= 1'b0;
            state      <= RECOVER;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == TIMEOUT) begin
              bus.MEM_EN <= 1'b0;
              bus.MIO_EN <= 1'b0;
              bus.DONE   <= 1'b1;
              bus.ERR    <= 1'b1;
              state      <= RECOVER;
            end
          end
        end
        RECOVER: begin
          if (!bus.R) begin
            bus.BUSY <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_requester.sv
// Directed bench for mem_requester with a behavioural memory responder and a
// scoreboard of expected {ERR, RDATA} popped on every DONE pulse.
module tb_mem_requester;

  localparam int unsigned TO = 15;

  typedef struct packed {
    logic        err;
    logic [15:0] rdata;
  } sb_t;

  logic i_Clk;
  logic i_Rst_n;
  mem_requester_if bus();

  mem_requester #(.TIMEOUT_CYCLES(TO), .IO_BASE(16'hFE00)) dut (
    .i_Clk  (i_Clk),
    .i_Rst_n(i_Rst_n),
    .bus    (bus)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  // responder: 0 = normal four-phase, 1 = never ready, 2 = ready stuck high
  int          resp_mode;
  logic [15:0] mem [0:65535];

  always @(posedge i_Clk) begin
    case (resp_mode)
      0: begin
        bus.R <= bus.MEM_EN;
        if (bus.MEM_EN && bus.RW && !bus.R) mem[bus.MAR_OUT] <= bus.MDR_OUT;
      end
      1:       bus.R <= 1'b0;
      default: bus.R <= 1'b1;
    endcase
  end

  assign bus.MEM_RDATA = mem[bus.MAR_OUT];

  int          total;
  int          bad;
  int          done_cnt;
  sb_t         exp_q[$];
  logic [15:0] model_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    sb_t e;
    @(posedge i_Clk);
    #1;
    if (bus.DONE === 1'b1) begin
      done_cnt++;
      chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_err", 32'(bus.ERR), 32'(e.err));
        chk("sb_rdata", 32'(bus.RDATA), 32'(e.rdata));
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.BUSY && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, 32'(bus.BUSY), 32'd0);
  endtask

  task automatic do_access(input string tag, input logic rw, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [15:0] exp_rdata);
    int d0;
    d0 = done_cnt;
    bus.REQ       = 1'b1;
    bus.REQ_RW    = rw;
    bus.REQ_ADDR  = addr;
    bus.REQ_WDATA = wdata;
    exp_q.push_back('{err: 1'b0, rdata: exp_rdata});
    tick();
    chk({tag, "_accept"}, 32'(bus.BUSY), 32'd1);
    bus.REQ = 1'b0;
    wait_idle(tag);
    chk({tag, "_one_done"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int accepts;
    int acc_tick [2];
    logic prev_busy;

    total = 0; bad = 0; done_cnt = 0;
    resp_mode     = 0;
    model_rdata   = 16'h0000;
    mem[16'h3000] <= 16'hBEEF;
    mem[16'h3001] <= 16'h0000;
    i_Rst_n       = 1'b0;
    bus.R         <= 1'b0;
    // REQ held during reset must be ignored
    bus.REQ       = 1'b1;
    bus.REQ_RW    = 1'b0;
    bus.REQ_ADDR  = 16'h3000;
    bus.REQ_WDATA = 16'h0000;
    tick(); tick();
    chk("rst_busy",   32'(bus.BUSY),    32'd0);
    chk("rst_mem_en", 32'(bus.MEM_EN),  32'd0);
    chk("rst_mio_en", 32'(bus.MIO_EN),  32'd0);
    chk("rst_mar",    32'(bus.MAR_OUT), 32'd0);
    chk("rst_mdr",    32'(bus.MDR_OUT), 32'd0);
    chk("rst_rw",     32'(bus.RW),      32'd0);
    chk("rst_done",   32'(bus.DONE),    32'd0);
    chk("rst_err",    32'(bus.ERR),     32'd0);
    chk("rst_rdata",  32'(bus.RDATA),   32'd0);
    bus.REQ = 1'b0;
    tick();
    i_Rst_n = 1'b1;
    tick();

    // nominal read, latency checked edge by edge
    bus.REQ      = 1'b1;
    bus.REQ_RW   = 1'b0;
    bus.REQ_ADDR = 16'h3000;
    exp_q.push_back('{err: 1'b0, rdata: 16'hBEEF});
    model_rdata = 16'hBEEF;
    tick();
    chk("rd_e0_busy",   32'(bus.BUSY),    32'd1);
    chk("rd_e0_mem_en", 32'(bus.MEM_EN),  32'd1);
    chk("rd_e0_mar",    32'(bus.MAR_OUT), 32'h3000);
    chk("rd_e0_mio",    32'(bus.MIO_EN),  32'd0);
    bus.REQ = 1'b0;
    tick();
    chk("rd_e1_done",   32'(bus.DONE),    32'd0);
    chk("rd_e1_r",      32'(bus.R),       32'd1);
    chk("rd_e1_mio",    32'(bus.MIO_EN),  32'd0);
    tick();
    chk("rd_e2_done",   32'(bus.DONE),    32'd1);
    chk("rd_e2_mem_en", 32'(bus.MEM_EN),  32'd0);
    tick();
    chk("rd_e3_done",   32'(bus.DONE),    32'd0);
    chk("rd_e3_busy",   32'(bus.BUSY),    32'd1);
    tick();
    chk("rd_e4_busy",   32'(bus.BUSY),    32'd0);

    // write then read back; write leaves RDATA alone
    do_access("wr", 1'b1, 16'h3001, 16'h1234, model_rdata);
    chk("wr_rdata_held", 32'(bus.RDATA), 32'hBEEF);
    do_access("rd2", 1'b0, 16'h3001, 16'h0000, 16'h1234);
    model_rdata = 16'h1234;

    // IO read against a silent responder -> timeout
    resp_mode    = 1;
    bus.REQ      = 1'b1;
    bus.REQ_RW   = 1'b0;
    bus.REQ_ADDR = 16'hFE01;
    exp_q.push_back('{err: 1'b1, rdata: model_rdata});
    tick();
    chk("io_mio_en", 32'(bus.MIO_EN), 32'd1);
    chk("io_mem_en", 32'(bus.MEM_EN), 32'd1);
    bus.REQ = 1'b0;
    for (int k = 1; k < int'(TO); k++) begin
      tick();
      chk("io_no_early_done", 32'(bus.DONE),   32'd0);
      chk("io_mio_held",      32'(bus.MIO_EN), 32'd1);
    end
    tick();
    chk("io_to_done",  32'(bus.DONE),   32'd1);
    chk("io_to_err",   32'(bus.ERR),    32'd1);
    chk("io_to_mio",   32'(bus.MIO_EN), 32'd0);
    chk("io_to_rdata", 32'(bus.RDATA),  32'h1234);
    resp_mode = 0;
    wait_idle("io");
    chk("io_err_held", 32'(bus.ERR), 32'd1);

    // stale ready blocks acceptance
    resp_mode = 2;
    tick();
    bus.REQ      = 1'b1;
    bus.REQ_RW   = 1'b0;
    bus.REQ_ADDR = 16'h3000;
    exp_q.push_back('{err: 1'b0, rdata: 16'hBEEF});
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stale_no_accept", 32'(bus.BUSY), 32'd0);
    end
    resp_mode = 0;
    tick();
    chk("stale_r_dropped", 32'(bus.R),    32'd0);
    chk("stale_still_idle", 32'(bus.BUSY), 32'd0);
    tick();
    chk("stale_accept", 32'(bus.BUSY), 32'd1);
    bus.REQ = 1'b0;
    model_rdata = 16'hBEEF;
    wait_idle("stale");
    chk("stale_err_clear", 32'(bus.ERR), 32'd0);

    // reset one cycle after acceptance aborts without DONE
    d0 = done_cnt;
    bus.REQ      = 1'b1;
    bus.REQ_RW   = 1'b1;
    bus.REQ_ADDR = 16'hFF00;
    bus.REQ_WDATA = 16'h5A5A;
    tick();
    chk("rst_mid_accept", 32'(bus.BUSY), 32'd1);
    bus.REQ = 1'b0;
    tick();
    i_Rst_n = 1'b0;
    tick();
    chk("rstm_mem_en", 32'(bus.MEM_EN),  32'd0);
    chk("rstm_busy",   32'(bus.BUSY),    32'd0);
    chk("rstm_done",   32'(bus.DONE),    32'd0);
    chk("rstm_mar",    32'(bus.MAR_OUT), 32'd0);
    chk("rstm_mdr",    32'(bus.MDR_OUT), 32'd0);
    chk("rstm_rw",     32'(bus.RW),      32'd0);
    chk("rstm_mio",    32'(bus.MIO_EN),  32'd0);
    chk("rstm_err",    32'(bus.ERR),     32'd0);
    chk("rstm_rdata",  32'(bus.RDATA),   32'd0);
    i_Rst_n = 1'b1;
    model_rdata = 16'h0000;
    tick(); tick(); tick();
    chk("rstm_no_done", 32'(done_cnt - d0), 32'd0);

    // back-to-back with REQ held: second accepted only after return to IDLE
    d0 = done_cnt;
    accepts = 0;
    acc_tick[0] = 0;
    acc_tick[1] = 0;
    prev_busy = 1'b0;
    bus.REQ      = 1'b1;
    bus.REQ_RW   = 1'b0;
    bus.REQ_ADDR = 16'h3000;
    exp_q.push_back('{err: 1'b0, rdata: 16'hBEEF});
    exp_q.push_back('{err: 1'b0, rdata: 16'h1234});
    for (int i = 0; i < 14; i++) begin
      tick();
      if (bus.BUSY && !prev_busy && accepts < 2) begin
        acc_tick[accepts] = i;
        accepts++;
        if (accepts == 1) bus.REQ_ADDR = 16'h3001;
        if (accepts == 2) bus.REQ = 1'b0;
      end
      if (accepts == 1 && bus.BUSY) chk("b2b_mar_stable", 32'(bus.MAR_OUT), 32'h3000);
      prev_busy = bus.BUSY;
    end
    chk("b2b_accepts",  32'(accepts),                   32'd2);
    chk("b2b_gap",      32'(acc_tick[1] - acc_tick[0]), 32'd5);
    chk("b2b_two_done", 32'(done_cnt - d0),             32'd2);
    chk("b2b_idle",     32'(bus.BUSY),                  32'd0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
